// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e    serialiser FSM encoding (IDLE/START/DATA/STOP)
//   UART_DATA_BITS  payload bits per 8N1 frame
//   UART_IDLE_LVL   line level for idle and the stop bit
//   UART_START_LVL  line level for the start bit
//   UART_CNT_W      width of the per-bit baud counter
//   clks_per_bit()  system clocks per serial bit (integer divide)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam int   UART_CNT_W     = 16;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the producer handshake and the serialiser.
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active-low; empties the queue
//   wr_en    in   push wr_data (ignored while full)
//   wr_data  in   WIDTH-bit entry
//   full     out  no room for another entry
//   rd_en    in   pop the head entry (ignored while empty)
//   rd_data  out  head entry, valid combinationally while !empty
//   empty    out  no entries held
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // One extra pointer bit tells a full queue apart from an empty one.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, with a small input FIFO.
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active-low; aborts any frame
//   data     in   byte to send, taken when valid && ready
//   valid    in   producer offers data
//   ready    out  FIFO has room (from registered state only)
//   tx       out  serial line, idle high, registered
//   busy     out  FIFO non-empty or a frame in progress
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | eight payload bits, LSB first, one bit period each
// STOP  | stop bit (high); chains straight into START if more is queued
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [UART_CNT_W-1:0] CNT_LAST = UART_CNT_W'(CPB - 1);
    localparam logic [UART_CNT_W-1:0] CNT_ONE  = UART_CNT_W'(1);
    localparam logic [2:0]            BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [UART_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            sh_q, sh_d;
    logic                  tx_q, tx_d;

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_rd_data;
    logic       bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (valid && ready),
        .wr_data (data),
        .full    (fifo_full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign ready   = !fifo_full;
    assign busy    = (state_q != IDLE) || !fifo_empty;
    assign tx      = tx_q;
    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            tx_q      <= UART_IDLE_LVL;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d      = UART_IDLE_LVL;
                clk_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_rd_data;
                    tx_d     = UART_START_LVL;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    tx_d      = sh_q[0];
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        tx_d    = UART_IDLE_LVL;
                        state_d = STOP;
                    end else begin
                        // Next bit is the one about to shift into sh[0].
                        sh_d      = sh_q >> 1;
                        tx_d      = sh_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (!fifo_empty) begin
                        // Back-to-back: the next start bit follows with no idle gap.
                        fifo_pop = 1'b1;
                        sh_d     = fifo_rd_data;
                        tx_d     = UART_START_LVL;
                        state_d  = START;
                    end else begin
                        tx_d    = UART_IDLE_LVL;
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_d    = UART_IDLE_LVL;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx at 10 clocks per bit.
module tb_uart_tx;

    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data;
    logic       valid;
    logic       ready, tx, busy;

    uart_tx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    typedef struct {
        logic [9:0] bits;
        int         start;
    } frame_t;

    vec_t   vec [13];
    frame_t mon_q [$];
    int     exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    // Line monitor: finds each start edge and samples mid-bit.
    logic       mon_active = 1'b0;
    logic       mon_prev   = 1'b1;
    int         mon_cnt    = 0;
    int         mon_start  = 0;
    logic [9:0] mon_bits   = '0;

    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
        end else begin
            if (!mon_active) begin
                if (mon_prev && !tx) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_start  = cyc;
                    mon_bits   = '0;
                end
            end else begin
                mon_cnt++;
            end
            if (mon_active && (mon_cnt % CPB) == CPB / 2) begin
                mon_bits[mon_cnt / CPB] = tx;
                if (mon_cnt == FRAME - CPB / 2) begin
                    mon_q.push_back('{bits: mon_bits, start: mon_start});
                    mon_active = 1'b0;
                end
            end
            mon_prev = tx;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int guard = 0;
        while (!ready && guard < 1000) begin
            tick();
            guard++;
        end
        check("send_ready", {31'd0, ready}, 32'd1);
        data  = b;
        valid = 1'b1;
        tick();
        acc_cyc = cyc;
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 2000) begin
            tick();
            guard++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        tick();
    endtask

    // Compares captured frames against vec[] entries listed in exp_q.
    task automatic check_frames(input string name, input bit contiguous);
        check($sformatf("%s_count", name), mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            check($sformatf("%s_frame%0d", name, i), {22'd0, mon_q[i].bits}, {22'd0, vec[exp_q[i]].frame});
            if (contiguous && i > 0)
                check($sformatf("%s_gap%0d", name, i), mon_q[i].start - mon_q[i-1].start, FRAME);
        end
    endtask

    initial begin
        int n, s, t, bad, accepted, first_stall;
        bit stalled;

        vec[0]  = '{8'hA5, 10'b1_10100101_0};
        vec[1]  = '{8'h00, 10'b1_00000000_0};
        vec[2]  = '{8'hFF, 10'b1_11111111_0};
        vec[3]  = '{8'h55, 10'b1_01010101_0};
        vec[4]  = '{8'h3C, 10'b1_00111100_0};
        vec[5]  = '{8'h11, 10'b1_00010001_0};
        vec[6]  = '{8'h22, 10'b1_00100010_0};
        vec[7]  = '{8'h33, 10'b1_00110011_0};
        vec[8]  = '{8'h44, 10'b1_01000100_0};
        vec[9]  = '{8'h81, 10'b1_10000001_0};
        vec[10] = '{8'hC3, 10'b1_11000011_0};
        vec[11] = '{8'h0F, 10'b1_00001111_0};
        vec[12] = '{8'h5A, 10'b1_01011010_0};

        reset_n = 1'b0;
        valid   = 1'b0;
        data    = 8'h00;
        repeat (3) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // 1. Single byte latency, bit pattern and busy drop.
        mon_q.delete();
        send_byte(vec[0].din, n);
        check("t1_tx_after_N", {31'd0, tx}, 32'd1);
        check("t1_busy_after_N", {31'd0, busy}, 32'd1);
        tick();
        check("t1_tx_low_by_N2", {31'd0, tx}, 32'd0);
        wait_cyc(n + FRAME);
        check("t1_busy_last", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_drop", {31'd0, busy}, 32'd0);
        check("t1_tx_idle", {31'd0, tx}, 32'd1);
        exp_q = '{0};
        check_frames("t1", 1'b0);
        if (mon_q.size() > 0) check("t1_start", mon_q[0].start, n + 1);

        // 2. Four bytes from the table, received in order.
        mon_q.delete();
        exp_q = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++) send_byte(vec[exp_q[i]].din, n);
        wait_idle();
        check_frames("t2", 1'b1);

        // 3. Six bytes with valid held high.
        mon_q.delete();
        accepted = 0;
        first_stall = -1;
        stalled = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data  = vec[5 + i].din;
            valid = 1'b1;
            t = 0;
            while (!ready && t < 1000) begin
                if (!stalled) begin
                    stalled = 1'b1;
                    first_stall = accepted;
                end
                tick();
                t++;
            end
            tick();
            accepted++;
        end
        valid = 1'b0;
        check("t3_accept_before_stall", first_stall, 5);
        wait_idle();
        exp_q = '{5, 6, 7, 8, 9, 10};
        check_frames("t3", 1'b1);

        // 4. Full FIFO ignores 0x99; ready returns right after the next pop.
        mon_q.delete();
        for (int i = 0; i < 5; i++) send_byte(vec[5 + i].din, n);
        s = n - 3;
        data  = 8'h99;
        valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready) bad++;
            tick();
        end
        valid = 1'b0;
        check("t4_ready_low_while_full", bad, 0);
        t = 0;
        while (!ready && t < 500) begin
            tick();
            t++;
        end
        check("t4_ready_rise_cyc", cyc, s + FRAME);
        wait_idle();
        exp_q = '{5, 6, 7, 8, 9};
        check_frames("t4", 1'b1);

        // 5. Reset during data bit 3 of 0x0F with two bytes queued.
        mon_q.delete();
        send_byte(vec[11].din, n);
        s = n + 1;
        send_byte(vec[5].din, n);
        send_byte(vec[6].din, n);
        wait_cyc(s + 45);
        check("t5_tx_bit3", {31'd0, tx}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_tx", {31'd0, tx}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_ready", {31'd0, ready}, 32'd1);
        repeat (3) tick();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!tx || busy) bad++;
        end
        check("t5_quiet_after_reset", bad, 0);
        check("t5_no_frames", mon_q.size(), 0);
        send_byte(vec[12].din, n);
        wait_idle();
        exp_q = '{12};
        check_frames("t5", 1'b0);

        // 6. Push on the STOP-end edge while one byte is queued.
        mon_q.delete();
        send_byte(vec[9].din, n);
        s = n + 1;
        send_byte(vec[4].din, n);
        wait_cyc(s + FRAME - 1);
        check("t6_ready_before_push", {31'd0, ready}, 32'd1);
        data  = vec[0].din;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("t6_busy_after_push", {31'd0, busy}, 32'd1);
        check("t6_tx_next_start", {31'd0, tx}, 32'd0);
        wait_cyc(s + 3 * FRAME - 1);
        check("t6_busy_before_end", {31'd0, busy}, 32'd1);
        tick();
        check("t6_busy_end", {31'd0, busy}, 32'd0);
        exp_q = '{9, 4, 0};
        check_frames("t6", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
